mat_ctrl: RTL

MAT_CTRL -- requirements
Module: mat_ctrl

---
 rtl/mat_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/mat_ctrl.sv
// 3x3 Q14.6 matrix-multiply sequencer: latches operands, drives the multiplier command, captures the product.
// Optional RUN timeout guarded by macro MAT_CTRL_TIMEOUT_EN.
module mat_ctrl #(
   parameter int TIMEOUT_CYC = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [188:0] req_a,
   input  logic [188:0] req_b,
   output logic [3:0]   mm_state,
   output logic [188:0] mm_a,
   output logic [188:0] mm_b,
   input  logic [188:0] mm_m,
   input  logic         mm_enable,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [188:0] rsp_m,
   output logic         rsp_err
);

   localparam logic [3:0] MM_IDLE = 4'b0000;
   localparam logic [3:0] MM_CLR  = 4'b0010;
   localparam logic [3:0] MM_RUN  = 4'b1001;

   // The counter is 6 bits, so the timeout has to fit in 1..64 cycles.
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 64) begin : g_bad_timeout
      $error("mat_ctrl: TIMEOUT_CYC out of range");
   end

   typedef enum logic [1:0] {IDLE, CLR, RUN, RSP} state_t;
   state_t state;

`ifdef MAT_CTRL_TIMEOUT_EN
   localparam logic [5:0] CNT_LAST = 6'(TIMEOUT_CYC - 1);
   logic [5:0] cnt;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mm_state  <= MM_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_m     <= '0;
         mm_a      <= '0;
         mm_b      <= '0;
`ifdef MAT_CTRL_TIMEOUT_EN
         rsp_err   <= 1'b0;
         cnt       <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (req_valid && req_ready) begin
               mm_a      <= req_a;
               mm_b      <= req_b;
               req_ready <= 1'b0;
               mm_state  <= MM_CLR;
               state     <= CLR;
            end
            CLR: begin
               mm_state <= MM_RUN;
               state    <= RUN;
`ifdef MAT_CTRL_TIMEOUT_EN
               cnt      <= '0;
`endif
            end
            RUN: begin
               if (mm_enable) begin
                  rsp_m     <= mm_m;
                  rsp_valid <= 1'b1;
                  mm_state  <= MM_IDLE;
                  state     <= RSP;
`ifdef MAT_CTRL_TIMEOUT_EN
                  rsp_err   <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  // Multiplier never answered: report an empty, flagged result.
                  rsp_m     <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  mm_state  <= MM_IDLE;
                  state     <= RSP;
               end else begin
                  cnt <= cnt + 6'd1;
`endif
               end
            end
            RSP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
